cic_decim_mc: RTL and testbench
===============================

// Module: cic_decim_mc
// PURPOSE
//  Multi-channel CIC decimator with internal decimation counter and output strobe generation.
//  NCH lock-step channels (e.g. I/Q) share one control path and one output strobe.
//  Normalises DC gain by N*ceil(log2(rate)), then applies 0..7 bits of extra gain with saturation.
//  Sits between the DDC mixer/CORDIC and the halfband stages; also flags clipping per channel.
// PARAMETERS
//  BW            16  sample width per channel, two's complement
//  N             4   CIC order (number of integrator and comb stages), 1..6
//  LOG2_MAX_RATE 7   log2 of the maximum decimation; accumulator width W = BW+N*LOG2_MAX_RATE
//  NCH           2   number of channels; channel c occupies bits [c*BW +: BW]
// PORTS
//  clock       in   1       single clock domain
//  reset       in   1       asynchronous, active-low; all registers cleared while low
//  enable      in   1       low = synchronous clear of datapath, counter and flags
//  rate        in   8       decimation R, legal values 1..2**LOG2_MAX_RATE; 0 is treated as 1
//  gain_bits   in   3       extra left shift 0..7 applied after normalisation
//  strobe_in   in   1       one input sample per channel is valid this cycle
//  signal_in   in   NCH*BW  input samples
//  strobe_out  out  1       one-cycle pulse: new signal_out value this cycle
//  signal_out  out  NCH*BW  decimated samples, held between strobe_out pulses
//  clip        out  NCH     sticky per-channel saturation flag
// BEHAVIOUR
//  Reset (reset low) or enable low: integrators, combs, counter, signal_out, clip and strobe_out are 0.
//  Rate latch: rate_q <= rate on enable rising and at each decimation boundary.
//    A rate change mid-period takes effect for the next period only.
//    shift_q = N*ceil(log2(rate_q)) is registered alongside rate_q.
//  Counter: on strobe_in, cnt counts 0..rate_q-1 and wraps.
//    dec_stb = strobe_in & (cnt == rate_q-1).
//    R=1: every strobe_in is a boundary.
//  Integrators (per channel, W bits, wrap modulo 2**W, never saturate):
//    on strobe_in, stage0 += sign-extended input; stage k += stage k-1.
//  Comb section: advances only on dec_stb.
//    sampler <= integrator[N-1];
//    stage k registered difference with one-sample delay, same structure as the single-channel block.
//    Comb output therefore lags the sampled integrator by N+1 output samples.
//    A bit-exact model must reproduce this lag.
//  Output pipeline, fixed at 3 clocks after the dec_stb cycle:
//    c1: arithmetic right shift by shift_q; keep BW+7 bits.
//    c2: take bits [BW-1+(7-gain_bits) -: BW] with saturation to +2**(BW-1)-1 / -2**(BW-1); set clip[c] on saturation.
//    c3: register into signal_out; strobe_out = 1 for exactly this cycle.
//  strobe_in spacing: any spacing >= 1 clock is legal, including back-to-back.
//    Output pipeline stages carry their own valid bit, so consecutive boundaries at R=1 are never lost.
//  Simultaneous events:
//    enable falling during a pipelined sample suppresses that strobe_out.
//    reset asserting mid-operation clears immediately, with no glitch pulse on strobe_out.
//  clip[c] is sticky until enable goes low or reset asserts.
//  gain_bits is sampled in c2 and may change at any time.
// TESTING
//  T1 Reset: reset low with random inputs -> signal_out=0, strobe_out=0, clip=0.
//     Release, enable=1, no strobe_in -> outputs stay 0.
//  T2 DC: N=4, rate=8, strobe_in every cycle, ch0=1000, ch1=-2000.
//     strobe_out every 8 clocks; after 6 outputs, ch0=1000 and ch1=-2000 exactly, clip=0.
//  T3 Gain/clip: rate=8, ch0=1000 with gain_bits=3 -> 8000, clip=0.
//     ch0=5000 with gain_bits=3 -> 32767, clip[0]=1, clip[1]=0.
//  T4 Full scale: rate=128, ch0=-32768 constant -> settles at -32768 exactly, no wrap artefact, clip=0.
//  T5 Rate change: rate 8->4 written 3 input strobes into a period.
//     Current period completes at 8; subsequent strobe_out every 4 strobe_in.
//     Outputs match a bit-exact model, shift 12->8.
//  T6 Disturbance: random strobe_in gaps vs model (R=1,5,128).
//     Then assert reset mid-period -> all outputs 0 next cycle, no strobe_out until a full new period plus 3 clocks.

Source files
------------

// File: rtl/cic_decim_mc.sv
// rtl/cic_decim_mc.sv - multi-channel CIC decimator with normalisation, gain and saturation
// Channels share the decimation counter and the output strobe pipeline.
module cic_decim_mc #(
  parameter int BW            = 16,
  parameter int N             = 4,
  parameter int LOG2_MAX_RATE = 7,
  parameter int NCH           = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        rate,
  input  logic [2:0]        gain_bits,
  input  logic              strobe_in,
  input  logic [NCH*BW-1:0] signal_in,
  output logic              strobe_out,
  output logic [NCH*BW-1:0] signal_out,
  output logic [NCH-1:0]    clip
);

  localparam int W  = BW + N*LOG2_MAX_RATE;
  localparam int CW = BW + 7;

  function automatic logic [5:0] shift_of(input logic [7:0] r);
    int l;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      if ((9'd1 << i) < {1'b0, r}) l = i + 1;
    end
    return 6'(N * l);
  endfunction

  logic       en_d;
  logic [7:0] rate_q;
  logic [5:0] shift_q;
  logic [7:0] cnt;
  logic [7:0] rate_eff;
  logic [7:0] rate_use;
  logic [5:0] shift_use;
  logic       dec_stb;
  logic       p0, v1, v2;
  logic [5:0] sh0;

  // In the first enabled cycle rate_q is not loaded yet, so use the live rate.
  assign rate_eff  = (rate == 8'd0) ? 8'd1 : rate;
  assign rate_use  = en_d ? rate_q : rate_eff;
  assign shift_use = en_d ? shift_q : shift_of(rate_eff);
  assign dec_stb   = enable & strobe_in & (cnt == rate_use - 8'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_d    <= 1'b0;
      rate_q  <= 8'd1;
      shift_q <= '0;
      cnt     <= '0;
    end else begin
      en_d <= enable;
      if (!enable) begin
        cnt <= '0;
      end else if (strobe_in) begin
        cnt <= dec_stb ? 8'd0 : cnt + 8'd1;
      end
      if (enable && (!en_d || dec_stb)) begin
        rate_q  <= rate_eff;
        shift_q <= shift_of(rate_eff);
      end
    end
  end

  // The shift of the period that just closed travels with its sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p0         <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      strobe_out <= 1'b0;
      sh0        <= '0;
    end else if (!enable) begin
      p0         <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      strobe_out <= 1'b0;
      sh0        <= '0;
    end else begin
      p0         <= dec_stb;
      v1         <= p0;
      v2         <= v1;
      strobe_out <= v2;
      if (dec_stb) sh0 <= shift_use;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [W-1:0]  x;
    logic signed [W-1:0]  integ [N];
    logic signed [W-1:0]  samp;
    logic signed [W-1:0]  comb [N];
    logic signed [W-1:0]  dly [N];
    logic signed [W+6:0]  ext;
    logic signed [CW-1:0] c1;
    logic signed [CW-1:0] c1_next;
    logic signed [CW-1:0] sc;
    logic                 fits;
    logic [BW-1:0]        c2;
    logic [BW-1:0]        c2_next;
    logic [BW-1:0]        sout;
    logic                 clip_r;

    assign x = {{(W-BW){signal_in[c*BW+BW-1]}}, signal_in[c*BW +: BW]};

    // Seven fraction bits are kept below the normalised value so gain_bits can recover them.
    always_comb begin
      ext     = {comb[N-1], 7'b0};
      c1_next = CW'(ext >>> sh0);
      sc      = c1 >>> (3'd7 - gain_bits);
      fits    = (sc[CW-1:BW-1] == {(CW-BW+1){sc[BW-1]}});
      c2_next = sc[BW-1:0];
      if (!fits) c2_next = sc[CW-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < N; k++) begin
          integ[k] <= '0;
          comb[k]  <= '0;
          dly[k]   <= '0;
        end
        samp   <= '0;
        c1     <= '0;
        c2     <= '0;
        sout   <= '0;
        clip_r <= 1'b0;
      end else if (!enable) begin
        for (int k = 0; k < N; k++) begin
          integ[k] <= '0;
          comb[k]  <= '0;
          dly[k]   <= '0;
        end
        samp   <= '0;
        c1     <= '0;
        c2     <= '0;
        sout   <= '0;
        clip_r <= 1'b0;
      end else begin
        if (strobe_in) begin
          integ[0] <= integ[0] + x;
          for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
        end
        if (dec_stb) begin
          samp    <= integ[N-1];
          comb[0] <= samp - dly[0];
          dly[0]  <= samp;
          for (int k = 1; k < N; k++) begin
            comb[k] <= comb[k-1] - dly[k];
            dly[k]  <= comb[k-1];
          end
        end
        if (p0) c1 <= c1_next;
        if (v1) begin
          c2 <= c2_next;
          if (!fits) clip_r <= 1'b1;
        end
        if (v2) sout <= c2;
      end
    end

    assign signal_out[c*BW +: BW] = sout;
    assign clip[c]                = clip_r;
  end

endmodule

// File: tb/tb_cic_decim_mc.sv
// tb/tb_cic_decim_mc.sv - scoreboard bench for cic_decim_mc
// A sample-level model predicts each decimated output and the clock it must appear on.
module tb_cic_decim_mc;

  localparam int BW  = 16;
  localparam int N   = 4;
  localparam int L   = 7;
  localparam int NCH = 2;
  localparam int W   = BW + N*L;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  rate;
  logic [2:0]  gain_bits;
  logic        strobe_in;
  logic [31:0] signal_in;
  logic        strobe_out;
  logic [31:0] signal_out;
  logic [1:0]  clip;

  cic_decim_mc #(.BW(BW), .N(N), .LOG2_MAX_RATE(L), .NCH(NCH)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .rate      (rate),
    .gain_bits (gain_bits),
    .strobe_in (strobe_in),
    .signal_in (signal_in),
    .strobe_out(strobe_out),
    .signal_out(signal_out),
    .clip      (clip)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic signed [W-1:0] m_integ [NCH][N];
  logic signed [W-1:0] m_comb  [NCH][N];
  logic signed [W-1:0] m_combd [NCH][N];
  logic signed [W-1:0] m_samp  [NCH];
  logic signed [W-1:0] m_sampd [NCH];
  logic [7:0]          m_cnt;
  logic [7:0]          m_rate_q;
  int                  m_shift_q;
  bit                  m_en_d;
  logic [1:0]          m_clip;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int shf(input int r);
    int l;
    l = 0;
    while ((1 << l) < r) l++;
    return N * l;
  endfunction

  function automatic logic [15:0] out_calc(input logic signed [W-1:0] v, input int su,
                                           input logic [2:0] g, output bit sat);
    longint            a;
    logic [22:0]       c1b;
    logic signed [22:0] c1;
    longint            t;
    a   = v;
    a   = a * 128;
    a   = a >>> su;
    c1b = a[22:0];
    c1  = signed'(c1b);
    t   = c1;
    t   = t >>> (7 - int'(g));
    sat = 1'b0;
    if (t > 32767) begin
      sat = 1'b1;
      return 16'h7fff;
    end
    if (t < -32768) begin
      sat = 1'b1;
      return 16'h8000;
    end
    return t[15:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < N; k++) begin
        m_integ[c][k] = '0;
        m_comb[c][k]  = '0;
        m_combd[c][k] = '0;
      end
      m_samp[c]  = '0;
      m_sampd[c] = '0;
    end
    m_cnt     = '0;
    m_rate_q  = 8'd1;
    m_shift_q = 0;
    m_en_d    = 1'b0;
    m_clip    = '0;
  endtask

  task automatic flush_from(input int c0);
    while (sb.size() > 0 && sb[$].cyc >= c0) void'(sb.pop_back());
  endtask

  // Predicts the effect of the current inputs at the next rising edge.
  task automatic model_step();
    logic [7:0]         re, ru;
    int                 su;
    bit                 dec, sat;
    exp_t               e;
    logic signed [15:0] xs;
    logic signed [W-1:0] xe;
    if (!enable) begin
      model_clear();
      flush_from(cyc + 1);
      return;
    end
    re  = (rate == 8'd0) ? 8'd1 : rate;
    ru  = m_en_d ? m_rate_q : re;
    su  = m_en_d ? m_shift_q : shf(int'(re));
    dec = strobe_in && (m_cnt == ru - 8'd1);
    e.data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (dec) begin
        for (int k = N - 1; k > 0; k--) begin
          m_combd[c][k] = m_comb[c][k];
          m_comb[c][k]  = m_comb[c][k-1] - m_combd[c][k-1];
        end
        m_combd[c][0] = m_comb[c][0];
        m_comb[c][0]  = m_samp[c] - m_sampd[c];
        m_sampd[c]    = m_samp[c];
        m_samp[c]     = m_integ[c][N-1];
        e.data[c*16 +: 16] = out_calc(m_comb[c][N-1], su, gain_bits, sat);
        if (sat) m_clip[c] = 1'b1;
      end
      if (strobe_in) begin
        for (int k = N - 1; k > 0; k--) m_integ[c][k] = m_integ[c][k] + m_integ[c][k-1];
        xs = signal_in[c*16 +: 16];
        xe = xs;
        m_integ[c][0] = m_integ[c][0] + xe;
      end
    end
    if (dec) begin
      e.cyc = cyc + 4;
      sb.push_back(e);
    end
    if (strobe_in) m_cnt = dec ? 8'd0 : m_cnt + 8'd1;
    if (!m_en_d || dec) begin
      m_rate_q  = re;
      m_shift_q = shf(int'(re));
    end
    m_en_d = 1'b1;
  endtask

  task automatic drive(input logic en, input logic [7:0] rt, input logic [2:0] gn,
                       input logic sin, input logic [31:0] din);
    @(posedge clock);
    #2;
    enable    = en;
    rate      = rt;
    gain_bits = gn;
    strobe_in = sin;
    signal_in = din;
    model_step();
  endtask

  task automatic run(input logic [7:0] rt, input logic [2:0] gn, input int n,
                     input int gap_pct, input logic [31:0] d, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic        s;
      logic [31:0] dd;
      s  = ($urandom_range(99) >= gap_pct);
      dd = rnd ? $urandom : d;
      drive(1'b1, rt, gn, s, dd);
    end
  endtask

  task automatic idle(input logic [7:0] rt, input logic [2:0] gn, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rt, gn, 1'b0, 32'h0);
  endtask

  task automatic drain_check(input string tag);
    for (int i = 0; i < 8; i++) drive(1'b1, rate, gain_bits, 1'b0, signal_in);
    check_eq({tag, "_drained"}, 64'(sb.size()), 64'd0);
    check_eq({tag, "_clip"}, 64'(clip), 64'(m_clip));
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && strobe_out) begin
      if (sb.size() == 0) begin
        check_eq("spurious_strobe", 64'(strobe_out), 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("data", 64'(signal_out), 64'(e.data));
        check_eq("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    rate      = 8'd8;
    gain_bits = 3'd0;
    strobe_in = 1'b0;
    signal_in = '0;
    model_clear();

    // T1: reset holds everything at zero whatever the inputs do
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #2;
      enable    = 1'($urandom);
      rate      = 8'($urandom);
      gain_bits = 3'($urandom);
      strobe_in = 1'($urandom);
      signal_in = $urandom;
      @(negedge clock);
      check_eq("rst_out", 64'(signal_out), 64'd0);
      check_eq("rst_stb", 64'(strobe_out), 64'd0);
      check_eq("rst_clip", 64'(clip), 64'd0);
    end
    @(posedge clock);
    #2;
    enable    = 1'b0;
    strobe_in = 1'b0;
    rate      = 8'd8;
    gain_bits = 3'd0;
    reset     = 1'b1;
    model_step();
    for (int i = 0; i < 20; i++) drive(1'b1, 8'd8, 3'd0, 1'b0, 32'h0);
    check_eq("idle_out", 64'(signal_out), 64'd0);
    check_eq("idle_clip", 64'(clip), 64'd0);

    // T2: DC at R=8 normalises back to the input
    idle(8'd8, 3'd0, 3);
    run(8'd8, 3'd0, 160, 0, {16'hf830, 16'h03e8}, 1'b0);
    drain_check("dc");
    check_eq("dc_value", 64'(signal_out), 64'h f830_03e8);
    check_eq("dc_clip0", 64'(clip), 64'd0);

    // T3: extra gain, then saturation on ch0 only
    idle(8'd8, 3'd3, 3);
    run(8'd8, 3'd3, 160, 0, {16'hf830, 16'h03e8}, 1'b0);
    drain_check("gain");
    check_eq("gain_value", 64'(signal_out), 64'h c180_1f40);
    run(8'd8, 3'd3, 160, 0, {16'hf830, 16'h1388}, 1'b0);
    drain_check("sat");
    check_eq("sat_value", 64'(signal_out), 64'h c180_7fff);
    check_eq("sat_clip", 64'(clip), 64'd1);

    // T4: most negative input at the maximum rate
    idle(8'd128, 3'd0, 3);
    run(8'd128, 3'd0, 1536, 0, {16'h0000, 16'h8000}, 1'b0);
    drain_check("fs");
    check_eq("fs_value", 64'(signal_out), 64'h 0000_8000);
    check_eq("fs_clip", 64'(clip), 64'd0);

    // T5: rate written three strobes into a period
    idle(8'd8, 3'd0, 3);
    run(8'd8, 3'd0, 40, 0, {16'hf830, 16'h03e8}, 1'b0);
    run(8'd8, 3'd0, 3, 0, {16'hf830, 16'h03e8}, 1'b0);
    run(8'd4, 3'd0, 80, 0, {16'hf830, 16'h03e8}, 1'b0);
    drain_check("rchg");

    // T6: random gaps and data across rates
    idle(8'd1, 3'd0, 3);
    run(8'd1, 3'($urandom_range(3)), 300, 40, 32'h0, 1'b1);
    drain_check("r1");
    idle(8'd5, 3'd0, 3);
    run(8'd5, 3'($urandom_range(3)), 400, 50, 32'h0, 1'b1);
    drain_check("r5");
    idle(8'd128, 3'd0, 3);
    run(8'd128, 3'd0, 1700, 50, 32'h0, 1'b1);
    drain_check("r128");

    // enable falling with samples in flight drops them
    idle(8'd1, 3'd0, 3);
    run(8'd1, 3'd0, 5, 0, 32'h0, 1'b1);
    idle(8'd1, 3'd0, 6);
    check_eq("dis_out", 64'(signal_out), 64'd0);

    // reset mid-period with samples in flight, then a clean restart
    idle(8'd8, 3'd0, 3);
    run(8'd8, 3'd0, 28, 0, 32'h0, 1'b1);
    @(posedge clock);
    #2;
    reset     = 1'b0;
    strobe_in = 1'b0;
    model_clear();
    flush_from(cyc);
    @(negedge clock);
    check_eq("mid_rst_out", 64'(signal_out), 64'd0);
    check_eq("mid_rst_stb", 64'(strobe_out), 64'd0);
    check_eq("mid_rst_clip", 64'(clip), 64'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    model_step();
    run(8'd8, 3'd0, 40, 0, 32'h0, 1'b1);
    drain_check("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
